// File: rtl/man_alu_pipe.sv
// rtl/man_alu_pipe.sv - two-stage mantissa add/subtract unit with valid/ready handshake; optional o_lzc under MAN_ALU_LZC_EN
module man_alu_pipe #(
    parameter int NUM_OP   = 1,
    parameter int SIZE_MAN = 28,
    parameter int LZC_W    = $clog2(SIZE_MAN + 1)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NUM_OP-1:0]   i_fpu_op,
    input  logic                i_sign_max,
    input  logic                i_sign_min,
    input  logic [SIZE_MAN-1:0] i_man_max,
    input  logic [SIZE_MAN-1:0] i_man_min,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_MAN-1:0] o_man_alu,
    output logic                o_overflow,
    output logic                o_eff_sub,
    output logic                o_zero
`ifdef MAN_ALU_LZC_EN
    ,
    output logic [LZC_W-1:0]    o_lzc
`endif
);

    // Stage valid bits and S1 operand registers
    logic                v1;
    logic                v2;
    logic [SIZE_MAN-1:0] s1_max;
    logic [SIZE_MAN-1:0] s1_min;
    logic                s1_eff_sub;

    logic eff_sub_in;
    logic advance2;
    logic accept;

    // Like signs subtract under SUB; unlike signs subtract under ADD.
    assign eff_sub_in = i_fpu_op[0] ? ~(i_sign_max ^ i_sign_min) : (i_sign_max ^ i_sign_min);

    // S1 may move into S2 when S2 is empty or its result is being consumed.
    assign advance2 = v1 && (!v2 || i_ready);
    assign o_ready  = !v1 || advance2;
    assign accept   = i_valid && o_ready;
    assign o_valid  = v2;

    // S1: capture operands on accept, empty when its content moves on
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v1         <= 1'b0;
            s1_max     <= '0;
            s1_min     <= '0;
            s1_eff_sub <= 1'b0;
        end else if (accept) begin
            v1         <= 1'b1;
            s1_max     <= i_man_max;
            s1_min     <= i_man_min;
            s1_eff_sub <= eff_sub_in;
        end else if (advance2) begin
            v1         <= 1'b0;
        end
    end

    // S2 arithmetic: max + min, or max + ~min + 1 for an effective subtract
    logic [SIZE_MAN-1:0] addend;
    logic [SIZE_MAN:0]   sum_full;
    logic [SIZE_MAN-1:0] sum;
    logic                carry;
    logic                ov_next;
    logic                zero_next;

    // Combinational adder feeding the S2 registers
    always_comb begin
        addend    = s1_eff_sub ? ~s1_min : s1_min;
        sum_full  = {1'b0, s1_max} + {1'b0, addend} + {{SIZE_MAN{1'b0}}, s1_eff_sub};
        carry     = sum_full[SIZE_MAN];
        sum       = sum_full[SIZE_MAN-1:0];
        // The subtract carry is the two's-complement artefact, not an overflow.
        ov_next   = !s1_eff_sub && carry;
        zero_next = (sum == '0) && !ov_next;
    end

`ifdef MAN_ALU_LZC_EN
    // Leading-zero count scanning from the MSB; an all-zero word yields SIZE_MAN.
    function automatic logic [LZC_W-1:0] count_lz(input logic [SIZE_MAN-1:0] value);
        logic [LZC_W-1:0] n;
        logic             found;
        n     = '0;
        found = 1'b0;
        for (int i = SIZE_MAN - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    n = n + LZC_W'(1);
                end
            end
        end
        return n;
    endfunction

    logic [LZC_W-1:0] lzc_next;

    // On overflow the normaliser shifts right, so no left-shift amount is reported.
    always_comb begin
        lzc_next = ov_next ? '0 : count_lz(sum);
    end
`endif

    // S2: register results on advance, hold while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            v2         <= 1'b0;
            o_man_alu  <= '0;
            o_overflow <= 1'b0;
            o_eff_sub  <= 1'b0;
            o_zero     <= 1'b0;
`ifdef MAN_ALU_LZC_EN
            o_lzc      <= '0;
`endif
        end else if (advance2) begin
            v2         <= 1'b1;
            o_man_alu  <= sum;
            o_overflow <= ov_next;
            o_eff_sub  <= s1_eff_sub;
            o_zero     <= zero_next;
`ifdef MAN_ALU_LZC_EN
            o_lzc      <= lzc_next;
`endif
        end else if (i_ready) begin
            v2         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_man_alu_pipe.sv
// tb/tb_man_alu_pipe.sv - self-checking bench for man_alu_pipe (vector table, directed sequences, random vs reference model)
module tb_man_alu_pipe;

    localparam int SM = 28;
    localparam int LW = $clog2(SM + 1);

    logic          i_clk;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [0:0]    i_fpu_op;
    logic          i_sign_max;
    logic          i_sign_min;
    logic [SM-1:0] i_man_max;
    logic [SM-1:0] i_man_min;
    logic          o_valid;
    logic          i_ready;
    logic [SM-1:0] o_man_alu;
    logic          o_overflow;
    logic          o_eff_sub;
    logic          o_zero;
`ifdef MAN_ALU_LZC_EN
    logic [LW-1:0] o_lzc;
`endif

    man_alu_pipe #(.NUM_OP(1), .SIZE_MAN(SM)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_fpu_op(i_fpu_op), .i_sign_max(i_sign_max), .i_sign_min(i_sign_min),
        .i_man_max(i_man_max), .i_man_min(i_man_min), .o_valid(o_valid), .i_ready(i_ready),
        .o_man_alu(o_man_alu), .o_overflow(o_overflow), .o_eff_sub(o_eff_sub), .o_zero(o_zero)
`ifdef MAN_ALU_LZC_EN
        , .o_lzc(o_lzc)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          op;
        logic          smax;
        logic          smin;
        logic [SM-1:0] mx;
        logic [SM-1:0] mn;
        logic [SM-1:0] e_man;
        logic          e_ov;
        logic          e_eff;
        logic          e_zero;
        int            e_lzc;
    } vec_t;

    typedef struct {
        logic [SM-1:0] man;
        logic          ov;
        logic          eff;
        logic          zero;
        int            lzc;
    } res_t;

    int   checks = 0;
    int   failures = 0;
    int   tick_no = 0;
    int   accepts = 0;
    res_t expq[$];
    int   fire_ticks[$];
    logic hold_pending = 1'b0;
    res_t held;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer add/subtract of the magnitudes, bit length for the zero count
    function automatic res_t model(input logic op, input logic smax, input logic smin,
                                   input logic [SM-1:0] mx, input logic [SM-1:0] mn);
        res_t            r;
        longint unsigned t;
        longint unsigned v;
        int              bl;
        r.eff = (smax != smin) ^ op;
        t = r.eff ? (longint'(mx) - longint'(mn)) : (longint'(mx) + longint'(mn));
        r.man = t[SM-1:0];
        r.ov = t[SM];
        r.zero = (r.man == 0) && !r.ov;
        v = longint'(r.man);
        bl = 0;
        while (v != 0) begin
            v = v >> 1;
            bl++;
        end
        r.lzc = r.ov ? 0 : SM - bl;
        return r;
    endfunction

    function automatic res_t read_out();
        res_t c;
        c.man = o_man_alu;
        c.ov = o_overflow;
        c.eff = o_eff_sub;
        c.zero = o_zero;
`ifdef MAN_ALU_LZC_EN
        c.lzc = int'(o_lzc);
`else
        c.lzc = 0;
`endif
        return c;
    endfunction

    task automatic cmp_out(input string name, input res_t e, input res_t a);
        check({name, "_man"}, 64'(a.man), 64'(e.man));
        check({name, "_ov"}, 64'(a.ov), 64'(e.ov));
        check({name, "_eff"}, 64'(a.eff), 64'(e.eff));
        check({name, "_zero"}, 64'(a.zero), 64'(e.zero));
`ifdef MAN_ALU_LZC_EN
        check({name, "_lzc"}, 64'(a.lzc), 64'(e.lzc));
`endif
    endtask

    // One cycle: drive at negedge, observe just after, score output transfer and input accept
    task automatic tick(input logic v, input logic r, input logic op, input logic smax, input logic smin,
                        input logic [SM-1:0] mx, input logic [SM-1:0] mn, input logic chk_ready);
        res_t e;
        res_t cur;
        i_valid = v; i_ready = r; i_fpu_op = op; i_sign_max = smax; i_sign_min = smin;
        i_man_max = mx; i_man_min = mn;
        #1;
        cur = read_out();
        if (chk_ready) check("o_ready", 64'(o_ready), 64'((expq.size() < 2) || r));
        if (hold_pending && o_valid) cmp_out("hold", held, cur);
        hold_pending = o_valid && !r;
        held = cur;
        if (o_valid && r) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=valid expected=none (t=%0t)", $time);
            end else begin
                e = expq.pop_front();
                cmp_out("result", e, cur);
                fire_ticks.push_back(tick_no);
            end
        end
        if (v && o_ready) begin
            expq.push_back(model(op, smax, smin, mx, mn));
            accepts++;
        end
        tick_no++;
        @(negedge i_clk);
    endtask

    task automatic idle(input logic r);
        tick(1'b0, r, 1'b0, 1'b0, 1'b0, SM'($urandom), SM'($urandom), 1'b1);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_valid"}, 64'(o_valid), 64'(0));
        check({name, "_man"}, 64'(o_man_alu), 64'(0));
        check({name, "_ov"}, 64'(o_overflow), 64'(0));
        check({name, "_eff"}, 64'(o_eff_sub), 64'(0));
        check({name, "_zero"}, 64'(o_zero), 64'(0));
`ifdef MAN_ALU_LZC_EN
        check({name, "_lzc"}, 64'(o_lzc), 64'(0));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [SM-1:0] mx;
        logic [SM-1:0] mn;
        logic [SM-1:0] tmp;
        int            base;
        res_t          tv;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 28'h8000000, 28'h8000000, 28'h0000000, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 28'h0000005, 28'h0000003, 28'h0000002, 1'b0, 1'b1, 1'b0, 26};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 28'h1234567, 28'h1234567, 28'h0000000, 1'b0, 1'b1, 1'b1, 28};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 28'h0000010, 28'h0000001, 28'h0000011, 1'b0, 1'b0, 1'b0, 23};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 28'h0000001, 28'h0000000, 1'b1, 1'b0, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 28'hABCDEF0, 28'hABCDEF0, 28'h0000000, 1'b0, 1'b1, 1'b1, 28};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 28'h4000000, 28'h2000000, 28'h6000000, 1'b0, 1'b0, 1'b0, 1};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 28'h0000000, 28'h0000000, 28'h0000000, 1'b0, 1'b0, 1'b1, 28};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 28'h8000000, 28'h0000001, 28'h7FFFFFF, 1'b0, 1'b1, 1'b0, 1};

        // Reset with junk on the inputs
        i_rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1; i_fpu_op = 1'b1;
        i_sign_max = 1'b1; i_sign_min = 1'b0; i_man_max = 28'hFFFFFFF; i_man_min = 28'h0F0F0F0;
        repeat (3) @(negedge i_clk);
        check_zero_outputs("reset");
        i_rst_n = 1'b1; i_valid = 1'b0;
        @(negedge i_clk);
        #1;
        check("reset_ready", 64'(o_ready), 64'(1));
        check_zero_outputs("post_reset");
        @(negedge i_clk);

        // Vector table, one operation at a time with latency checks
        foreach (vecs[i]) begin
            tick(1'b1, 1'b1, vecs[i].op, vecs[i].smax, vecs[i].smin, vecs[i].mx, vecs[i].mn, 1'b1);
            #1;
            check($sformatf("vec%0d_lat1_valid", i), 64'(o_valid), 64'(0));
            idle(1'b1);
            #1;
            check($sformatf("vec%0d_lat2_valid", i), 64'(o_valid), 64'(1));
            tv = '{vecs[i].e_man, vecs[i].e_ov, vecs[i].e_eff, vecs[i].e_zero, vecs[i].e_lzc};
            cmp_out($sformatf("vec%0d", i), tv, read_out());
            idle(1'b1);
        end
        check("table_queue_empty", 64'(expq.size()), 64'(0));

        // Streaming: 8 back-to-back, results on consecutive cycles
        fire_ticks.delete();
        base = tick_no;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b1, 1'(i), 1'(i >> 1), 1'b0, 28'h0100000 * 28'(i + 1), 28'h0000011 * 28'(i), 1'b1);
        end
        repeat (6) idle(1'b1);
        check("stream_count", 64'(fire_ticks.size()), 64'(8));
        if (fire_ticks.size() == 8) begin
            check("stream_first", 64'(fire_ticks[0] - base), 64'(2));
            check("stream_last", 64'(fire_ticks[7] - base), 64'(9));
        end

        // Backpressure: only two accepted, first result held, then drain
        accepts = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0800000 + 28'(i), 28'h0000100 * 28'(i + 1), 1'b1);
        end
        check("bp_accepts", 64'(accepts), 64'(2));
        #1;
        check("bp_ready_low", 64'(o_ready), 64'(0));
        for (int i = 0; i < 10 && expq.size() > 0; i++) idle(1'b1);
        check("bp_drained", 64'(expq.size()), 64'(0));
        idle(1'b1);

        // Reset mid-flight discards both transactions
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 28'h0000777, 28'h0000001, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 28'h0000999, 28'h0000002, 1'b1);
        check("rst_inflight", 64'(expq.size()), 64'(2));
        i_rst_n = 1'b0; i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        check_zero_outputs("midrst");
        check("midrst_ready", 64'(o_ready), 64'(1));
        expq.delete();
        hold_pending = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("midrst_no_stale", 64'(o_valid), 64'(0));
        end

        // Random traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            mx = SM'($urandom);
            mn = SM'($urandom);
            if ($urandom_range(0, 3) == 0) mn = mx;
            if ($urandom_range(0, 3) == 0) begin
                mx[SM-1] = 1'b1;
                mn[SM-1] = 1'b1;
            end
            if (mn > mx) begin
                tmp = mx; mx = mn; mn = tmp;
            end
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                 1'($urandom), mx, mn, 1'b1);
        end
        for (int i = 0; i < 20 && expq.size() > 0; i++) idle(1'b1);
        check("random_drained", 64'(expq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/man_alu_pipe.md
Name: man_alu_pipe

Overview:
- Pipelined, parametrised mantissa add/subtract unit for the FP ADD/SUB datapath. It is the successor to the single-cycle combinational mantissa ALU.
- Resolves the effective operation from the op code and operand signs. Then computes max ± min, registered across two stages with valid/ready backpressure.
- Adds a zero-result flag and an effective-subtract flag. A leading-zero count for the normaliser is optional.
- Sits between the exponent-align/swap stage (upstream) and the normalise/round stage (downstream).

Parameters:
- NUM_OP, 1, width of i_fpu_op (bit 0 used: 0 = ADD, 1 = SUB).
- SIZE_MAN, 28, mantissa width including guard/round/sticky bits; legal range 8..64.
- LZC_W, $clog2(SIZE_MAN+1), width of the leading-zero count (derived; do not override).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  upstream operand valid.
- o_ready  out  1  block can accept operands this cycle.
- i_fpu_op  in  NUM_OP  requested operation.
- i_sign_max  in  1  sign of the larger-magnitude operand.
- i_sign_min  in  1  sign of the smaller-magnitude operand.
- i_man_max  in  SIZE_MAN  aligned mantissa of the larger operand.
- i_man_min  in  SIZE_MAN  aligned mantissa of the smaller operand; guaranteed ≤ i_man_max.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_man_alu  out  SIZE_MAN  mantissa result.
- o_overflow  out  1  carry-out of an effective add.
- o_eff_sub  out  1  result came from an effective subtraction.
- o_zero  out  1  result is exactly zero with no overflow.
- o_lzc  out  LZC_W  leading zeros of o_man_alu (present only with MAN_ALU_LZC_EN).

Behaviour:
- Effective subtract: eff_sub = i_fpu_op[0] ? ~(i_sign_max ^ i_sign_min) : (i_sign_max ^ i_sign_min).
- Stage 1 (S1) registers i_man_max, i_man_min, and eff_sub. S1 captures when i_valid && o_ready.
- Stage 2 (S2) computes {carry, sum} = max + (eff_sub ? ~min : min) + eff_sub, at SIZE_MAN+1 bits. It registers:
  - o_man_alu = sum[SIZE_MAN-1:0];
  - o_overflow = eff_sub ? 0 : carry;
  - o_zero = (sum == 0) && !o_overflow;
  - o_eff_sub = eff_sub.
- Effective subtraction never goes negative, because min ≤ max. Results are modulo 2^SIZE_MAN and carry is discarded.
- Latency is 2 cycles from the accepting edge to o_valid high. Throughput is 1 result per cycle when i_ready is held high.
- Handshake, with stage valid bits v1 and v2:
  - advance2 = v1 && (!v2 || i_ready);
  - o_ready = !v1 || advance2 (combinational; depends on i_ready);
  - o_valid = v2.
- Output hold: while o_valid && !i_ready, all outputs stay stable and S2 does not update.
- S1 holds when it cannot advance. At most 2 transactions are in flight; none is dropped or reordered.
- Simultaneous accept at S1, advance into S2, and consume at the output in one cycle is legal and required for full throughput.
- Reset, when i_rst_n == 0 at a clock edge:
  - v1 = v2 = 0; all data registers and outputs = 0 (o_lzc = 0).
  - o_ready reads 1 the cycle after reset is released.
- Reset mid-operation discards in-flight transactions; no spurious o_valid follows.
- Inputs are ignored when i_valid == 0. The data registers are not updated.

Optional Feature:
- Macro: MAN_ALU_LZC_EN.
- Defined:
  - o_lzc exists and is registered in S2 alongside o_man_alu.
  - o_lzc = the number of leading zero bits of sum[SIZE_MAN-1:0], giving SIZE_MAN when the sum is zero.
  - When o_overflow = 1, o_lzc reports 0. The normaliser shifts right in that case.
- Not defined: the o_lzc port and its logic are absent. All other behaviour is identical.

Test Plan (SIZE_MAN = 28):
- Add overflow: op=0, signs 0/0, max=min=0x8000000 → after 2 cycles o_man_alu=0x0000000, o_overflow=1, o_zero=0, o_eff_sub=0, o_lzc=0.
- Subtract: op=1, signs 0/0, max=0x0000005, min=0x0000003 → o_man_alu=0x0000002, o_overflow=0, o_eff_sub=1, o_zero=0, o_lzc=26.
- Cancellation: op=0, signs 0/1, max=min=0x1234567 → o_man_alu=0, o_zero=1, o_eff_sub=1, o_lzc=28.
- Streaming:
  - 8 back-to-back valid inputs with i_ready=1 → 8 results on consecutive cycles, the first 2 cycles after the first accept, in order.
  - o_ready stays 1 throughout.
- Backpressure:
  - i_ready=0 for 6 cycles while i_valid=1 → exactly 2 accepted, then o_ready=0.
  - The first result is held stable the whole time.
  - Raising i_ready drains all results in order with no loss or duplication.
- Reset mid-flight: 2 transactions in flight, then i_rst_n=0 for 1 cycle → o_valid=0 and all outputs 0; no stale result emerges afterwards.
